// File: rtl/spmv_mem_arb_pkg.sv
// Shared types and default widths for the SpMV memory arbiter.
package spmv_mem_pkg;

    // Default widths, matching the DCP NoC port and the SpMV engine tags.
    localparam int NUM_REQ_D   = 4;
    localparam int ADDR_W_D    = 40;
    localparam int DATA_W_D    = 64;
    localparam int TID_W_D     = 6;
    localparam int TAG_W_D     = 4;
    localparam int MAX_OUTST_D = 16;
    localparam int OWN_W_D     = $clog2(NUM_REQ_D);

    // Requester slots on the arbiter.
    localparam int REQ_VEC    = 0;
    localparam int REQ_ROWPTR = 1;
    localparam int REQ_COLIDX = 2;
    localparam int REQ_VAL    = 3;

    // One outstanding-request table entry.
    typedef struct packed {
        logic               valid;
        logic [OWN_W_D-1:0] owner;
        logic [TAG_W_D-1:0] tag;
    } mem_entry_t;

endpackage

// File: rtl/spmv_mem_arb_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt
);

    logic             found;
    logic [PTR_W-1:0] sel;

    // Scan requesters starting at the pointer, wrapping, and keep the first hit.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        sel   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sel = PTR_W'((int'(ptr) + k) % NUM_REQ);
            if (!found && req[sel]) begin
                gnt[sel] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spmv_mem_arb.sv
// Shares the DCP NoC memory port among the SpMV fetch engines: round-robin
// grant, transaction-ID allocation from an outstanding table, response routing.
module spmv_mem_arb
    import spmv_mem_pkg::*;
#(
    parameter int NUM_REQ   = NUM_REQ_D,
    parameter int ADDR_W    = ADDR_W_D,
    parameter int DATA_W    = DATA_W_D,
    parameter int TID_W     = TID_W_D,
    parameter int TAG_W     = TAG_W_D,
    parameter int MAX_OUTST = MAX_OUTST_D
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              drain,
    input  logic [NUM_REQ-1:0]                req_val,
    input  logic [NUM_REQ*ADDR_W-1:0]         req_addr,
    input  logic [NUM_REQ*TAG_W-1:0]          req_tag,
    output logic [NUM_REQ-1:0]                req_rdy,
    output logic                              mem_req_val,
    input  logic                              mem_req_rdy,
    output logic [TID_W-1:0]                  mem_req_transid,
    output logic [ADDR_W-1:0]                 mem_req_addr,
    input  logic                              mem_resp_val,
    input  logic [TID_W-1:0]                  mem_resp_transid,
    input  logic [DATA_W-1:0]                 mem_resp_data,
    output logic [NUM_REQ-1:0]                resp_val,
    output logic [TAG_W-1:0]                  resp_tag,
    output logic [DATA_W-1:0]                 resp_data,
    output logic [$clog2(MAX_OUTST):0]        outst_cnt,
    output logic                              idle,
    output logic                              err_stray
);

    localparam int OWN_W = $clog2(NUM_REQ);
    localparam int IDX_W = $clog2(MAX_OUTST);
    localparam int CNT_W = IDX_W + 1;

    mem_entry_t           tbl [MAX_OUTST];
    logic [OWN_W-1:0]     rr_ptr;

    logic                 out_free;
    logic                 grant_en;
    logic                 alloc;
    logic                 free_any;
    logic [IDX_W-1:0]     free_idx;
    logic [NUM_REQ-1:0]   gnt;
    logic [OWN_W-1:0]     win_idx;
    logic [ADDR_W-1:0]    win_addr;
    logic [TAG_W-1:0]     win_tag;

    logic [IDX_W-1:0]     resp_idx;
    logic                 resp_in_range;
    logic                 resp_hit;
    mem_entry_t           resp_ent;
    logic [NUM_REQ-1:0]   resp_onehot;

    // Output register can take a new request when empty or handing off now.
    assign out_free = !mem_req_val || mem_req_rdy;

    // Lowest free table index; the bitmap is the registered valid bits.
    always_comb begin
        free_any = 1'b0;
        free_idx = '0;
        for (int i = MAX_OUTST - 1; i >= 0; i--) begin
            if (!tbl[i].valid) begin
                free_any = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    // rst_n gating keeps req_rdy low while reset is held.
    assign grant_en = rst_n && !drain && free_any && out_free;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (OWN_W)
    ) u_rr_arbiter (
        .req (req_val & {NUM_REQ{grant_en}}),
        .ptr (rr_ptr),
        .gnt (gnt)
    );

    assign req_rdy = gnt;
    assign alloc   = |gnt;

    // Decode the one-hot grant into the winner's index, address and tag.
    always_comb begin
        win_idx  = '0;
        win_addr = '0;
        win_tag  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                win_idx  = OWN_W'(i);
                win_addr = req_addr[i*ADDR_W +: ADDR_W];
                win_tag  = req_tag[i*TAG_W +: TAG_W];
            end
        end
    end

    // A response is accepted only for an in-range ID whose entry is live.
    assign resp_idx      = mem_resp_transid[IDX_W-1:0];
    assign resp_in_range = ({1'b0, mem_resp_transid} < (TID_W+1)'(MAX_OUTST));
    assign resp_ent      = tbl[resp_idx];
    assign resp_hit      = mem_resp_val && resp_in_range && resp_ent.valid;

    // One-hot strobe for the owner of the returning entry.
    always_comb begin
        resp_onehot = '0;
        resp_onehot[resp_ent.owner] = 1'b1;
    end

    // NoC request register: holds under backpressure, reloads on grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req_val     <= 1'b0;
            mem_req_transid <= '0;
            mem_req_addr    <= '0;
        end else if (out_free) begin
            mem_req_val <= alloc;
            if (alloc) begin
                mem_req_transid <= TID_W'(free_idx);
                mem_req_addr    <= win_addr;
            end
        end
    end

    // Outstanding table: allocate and free can hit different entries in one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_OUTST; i++) begin
                tbl[i] <= '0;
            end
        end else begin
            for (int i = 0; i < MAX_OUTST; i++) begin
                if (alloc && free_idx == IDX_W'(i)) begin
                    tbl[i].valid <= 1'b1;
                    tbl[i].owner <= win_idx;
                    tbl[i].tag   <= win_tag;
                end else if (resp_hit && resp_idx == IDX_W'(i)) begin
                    tbl[i].valid <= 1'b0;
                end
            end
        end
    end

    // Live-entry count; a same-cycle allocate and free cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outst_cnt <= '0;
        end else if (alloc && !resp_hit) begin
            outst_cnt <= outst_cnt + CNT_W'(1);
        end else if (!alloc && resp_hit) begin
            outst_cnt <= outst_cnt - CNT_W'(1);
        end
    end

    // Round-robin pointer moves just past the last winner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (alloc) begin
            rr_ptr <= (win_idx == OWN_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
        end
    end

    // Response register routed to the entry owner; stray responses are flagged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_val  <= '0;
            resp_tag  <= '0;
            resp_data <= '0;
            err_stray <= 1'b0;
        end else begin
            resp_val <= resp_hit ? resp_onehot : '0;
            if (resp_hit) begin
                resp_tag  <= resp_ent.tag;
                resp_data <= mem_resp_data;
            end
            if (mem_resp_val && !resp_hit) begin
                err_stray <= 1'b1;
            end
        end
    end

    assign idle = (outst_cnt == '0) && !mem_req_val;

endmodule

// File: tb/tb_spmv_mem_arb.sv
// Directed bench for spmv_mem_arb: grant, ID allocation, routing, drain, reset.
module tb_spmv_mem_arb;

    localparam int NR = 4;
    localparam int AW = 40;
    localparam int DW = 64;
    localparam int TW = 6;
    localparam int GW = 4;
    localparam int MO = 16;
    localparam int CW = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              drain = 1'b0;
    logic [NR-1:0]     req_val = '0;
    logic [NR*AW-1:0]  req_addr = '0;
    logic [NR*GW-1:0]  req_tag = '0;
    logic [NR-1:0]     req_rdy;
    logic              mem_req_val;
    logic              mem_req_rdy = 1'b0;
    logic [TW-1:0]     mem_req_transid;
    logic [AW-1:0]     mem_req_addr;
    logic              mem_resp_val = 1'b0;
    logic [TW-1:0]     mem_resp_transid = '0;
    logic [DW-1:0]     mem_resp_data = '0;
    logic [NR-1:0]     resp_val;
    logic [GW-1:0]     resp_tag;
    logic [DW-1:0]     resp_data;
    logic [CW-1:0]     outst_cnt;
    logic              idle;
    logic              err_stray;

    int tests = 0;
    int fails = 0;

    spmv_mem_arb dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .drain            (drain),
        .req_val          (req_val),
        .req_addr         (req_addr),
        .req_tag          (req_tag),
        .req_rdy          (req_rdy),
        .mem_req_val      (mem_req_val),
        .mem_req_rdy      (mem_req_rdy),
        .mem_req_transid  (mem_req_transid),
        .mem_req_addr     (mem_req_addr),
        .mem_resp_val     (mem_resp_val),
        .mem_resp_transid (mem_resp_transid),
        .mem_resp_data    (mem_resp_data),
        .resp_val         (resp_val),
        .resp_tag         (resp_tag),
        .resp_data        (resp_data),
        .outst_cnt        (outst_cnt),
        .idle             (idle),
        .err_stray        (err_stray)
    );

    always #5 clk = ~clk;

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        drain = 1'b0;
        req_val = '0;
        req_addr = '0;
        req_tag = '0;
        mem_req_rdy = 1'b0;
        mem_resp_val = 1'b0;
        mem_resp_transid = '0;
        mem_resp_data = '0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        #2 rst_n = 1'b0;
        req_val = 4'hF;
        mem_req_rdy = 1'b1;
        cyc();
        tests++; if (req_rdy !== 4'b0000) begin fails++; $display("FAIL reset_req_rdy got %b want 0000", req_rdy); end
        tests++; if (mem_req_val !== 1'b0) begin fails++; $display("FAIL reset_mem_req_val got %b want 0", mem_req_val); end
        tests++; if (resp_val !== 4'b0000) begin fails++; $display("FAIL reset_resp_val got %b want 0000", resp_val); end
        tests++; if (outst_cnt !== 5'd0) begin fails++; $display("FAIL reset_outst_cnt got %0d want 0", outst_cnt); end
        tests++; if (idle !== 1'b1) begin fails++; $display("FAIL reset_idle got %b want 1", idle); end
        tests++; if (err_stray !== 1'b0) begin fails++; $display("FAIL reset_err_stray got %b want 0", err_stray); end
        tests++; if (mem_req_transid !== 6'd0) begin fails++; $display("FAIL reset_transid got %0d want 0", mem_req_transid); end
        do_reset();
    endtask

    task automatic test_single;
        do_reset();
        req_val = 4'b0001;
        req_addr[0*AW +: AW] = 40'h1000;
        req_tag[0*GW +: GW] = 4'd3;
        mem_req_rdy = 1'b1;
        #1;
        tests++; if (req_rdy !== 4'b0001) begin fails++; $display("FAIL single_grant got %b want 0001", req_rdy); end
        cyc();
        req_val = 4'b0000;
        tests++; if (mem_req_val !== 1'b1) begin fails++; $display("FAIL single_mem_val got %b want 1", mem_req_val); end
        tests++; if (mem_req_transid !== 6'd0) begin fails++; $display("FAIL single_transid got %0d want 0", mem_req_transid); end
        tests++; if (mem_req_addr !== 40'h1000) begin fails++; $display("FAIL single_addr got %h want 1000", mem_req_addr); end
        tests++; if (outst_cnt !== 5'd1) begin fails++; $display("FAIL single_cnt1 got %0d want 1", outst_cnt); end
        tests++; if (idle !== 1'b0) begin fails++; $display("FAIL single_busy got %b want 0", idle); end
        mem_resp_val = 1'b1;
        mem_resp_transid = 6'd0;
        mem_resp_data = 64'hA5A5A5A5A5A5A5A5;
        cyc();
        mem_resp_val = 1'b0;
        tests++; if (resp_val !== 4'b0001) begin fails++; $display("FAIL single_resp_val got %b want 0001", resp_val); end
        tests++; if (resp_tag !== 4'd3) begin fails++; $display("FAIL single_resp_tag got %0d want 3", resp_tag); end
        tests++; if (resp_data !== 64'hA5A5A5A5A5A5A5A5) begin fails++; $display("FAIL single_resp_data got %h want a5a5a5a5a5a5a5a5", resp_data); end
        tests++; if (outst_cnt !== 5'd0) begin fails++; $display("FAIL single_cnt0 got %0d want 0", outst_cnt); end
        tests++; if (idle !== 1'b1) begin fails++; $display("FAIL single_idle got %b want 1", idle); end
        cyc();
        tests++; if (resp_val !== 4'b0000) begin fails++; $display("FAIL single_resp_clear got %b want 0000", resp_val); end
    endtask

    task automatic test_round_robin;
        logic [3:0]  exp_rdy;
        logic [39:0] exp_addr;
        do_reset();
        for (int i = 0; i < NR; i++) begin
            req_addr[i*AW +: AW] = 40'h2000 + 40'(i * 16);
            req_tag[i*GW +: GW] = 4'(8 + i);
        end
        req_val = 4'hF;
        mem_req_rdy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            exp_rdy = 4'b0001 << (k % 4);
            exp_addr = 40'h2000 + 40'((k % 4) * 16);
            #1;
            tests++; if (req_rdy !== exp_rdy) begin fails++; $display("FAIL rr_grant[%0d] got %b want %b", k, req_rdy, exp_rdy); end
            cyc();
            tests++; if (mem_req_transid !== 6'(k)) begin fails++; $display("FAIL rr_transid[%0d] got %0d want %0d", k, mem_req_transid, k); end
            tests++; if (mem_req_addr !== exp_addr) begin fails++; $display("FAIL rr_addr[%0d] got %h want %h", k, mem_req_addr, exp_addr); end
        end
        req_val = 4'h0;
        cyc();
        tests++; if (mem_req_val !== 1'b0) begin fails++; $display("FAIL rr_mem_val_off got %b want 0", mem_req_val); end
        tests++; if (outst_cnt !== 5'd5) begin fails++; $display("FAIL rr_cnt got %0d want 5", outst_cnt); end
    endtask

    // Runs on the table left by test_round_robin: owners 0,1,2,3,0 with tags 8,9,10,11,8.
    task automatic test_out_of_order;
        logic [5:0]  ids  [3];
        logic [3:0]  owns [3];
        logic [3:0]  tags [3];
        logic [63:0] dat;
        ids[0] = 6'd2; owns[0] = 4'b0100; tags[0] = 4'd10;
        ids[1] = 6'd0; owns[1] = 4'b0001; tags[1] = 4'd8;
        ids[2] = 6'd1; owns[2] = 4'b0010; tags[2] = 4'd9;
        for (int j = 0; j < 3; j++) begin
            dat = 64'hD0D0_0000_0000_0000 | 64'(j);
            mem_resp_val = 1'b1;
            mem_resp_transid = ids[j];
            mem_resp_data = dat;
            cyc();
            tests++; if (resp_val !== owns[j]) begin fails++; $display("FAIL ooo_owner[%0d] got %b want %b", j, resp_val, owns[j]); end
            tests++; if (resp_tag !== tags[j]) begin fails++; $display("FAIL ooo_tag[%0d] got %0d want %0d", j, resp_tag, tags[j]); end
            tests++; if (resp_data !== dat) begin fails++; $display("FAIL ooo_data[%0d] got %h want %h", j, resp_data, dat); end
        end
        mem_resp_val = 1'b0;
        tests++; if (outst_cnt !== 5'd2) begin fails++; $display("FAIL ooo_cnt got %0d want 2", outst_cnt); end
        tests++; if (err_stray !== 1'b0) begin fails++; $display("FAIL ooo_no_stray got %b want 0", err_stray); end
        mem_resp_val = 1'b1;
        mem_resp_transid = 6'd9;
        cyc();
        mem_resp_val = 1'b0;
        tests++; if (resp_val !== 4'b0000) begin fails++; $display("FAIL stray_dropped got %b want 0000", resp_val); end
        tests++; if (err_stray !== 1'b1) begin fails++; $display("FAIL stray_flag got %b want 1", err_stray); end
        tests++; if (outst_cnt !== 5'd2) begin fails++; $display("FAIL stray_cnt got %0d want 2", outst_cnt); end
        cyc();
        tests++; if (err_stray !== 1'b1) begin fails++; $display("FAIL stray_sticky got %b want 1", err_stray); end
    endtask

    task automatic test_backpressure;
        do_reset();
        req_val = 4'b0001;
        req_addr[0*AW +: AW] = 40'h3000;
        req_tag[0*GW +: GW] = 4'd1;
        mem_req_rdy = 1'b0;
        #1;
        tests++; if (req_rdy !== 4'b0001) begin fails++; $display("FAIL bp_first_grant got %b want 0001", req_rdy); end
        cyc();
        req_addr[0*AW +: AW] = 40'h3008;
        for (int c = 0; c < 5; c++) begin
            #1;
            tests++; if (req_rdy !== 4'b0000) begin fails++; $display("FAIL bp_no_grant[%0d] got %b want 0000", c, req_rdy); end
            tests++; if (mem_req_val !== 1'b1 || mem_req_transid !== 6'd0 || mem_req_addr !== 40'h3000) begin
                fails++; $display("FAIL bp_stable[%0d] got val=%b id=%0d addr=%h want val=1 id=0 addr=3000", c, mem_req_val, mem_req_transid, mem_req_addr);
            end
            cyc();
        end
        mem_req_rdy = 1'b1;
        #1;
        tests++; if (req_rdy !== 4'b0001) begin fails++; $display("FAIL bp_release_grant got %b want 0001", req_rdy); end
        cyc();
        tests++; if (mem_req_val !== 1'b1 || mem_req_transid !== 6'd1 || mem_req_addr !== 40'h3008) begin
            fails++; $display("FAIL bp_second got val=%b id=%0d addr=%h want val=1 id=1 addr=3008", mem_req_val, mem_req_transid, mem_req_addr);
        end
        tests++; if (req_rdy !== 4'b0001) begin fails++; $display("FAIL bp_b2b_grant got %b want 0001", req_rdy); end
        cyc();
        tests++; if (mem_req_transid !== 6'd2) begin fails++; $display("FAIL bp_third got %0d want 2", mem_req_transid); end
        req_val = 4'b0000;
        cyc();
        tests++; if (mem_req_val !== 1'b0 || outst_cnt !== 5'd3) begin
            fails++; $display("FAIL bp_end got val=%b cnt=%0d want val=0 cnt=3", mem_req_val, outst_cnt);
        end
    endtask

    task automatic test_full;
        do_reset();
        req_val = 4'b0010;
        req_addr[1*AW +: AW] = 40'h4000;
        req_tag[1*GW +: GW] = 4'd5;
        mem_req_rdy = 1'b1;
        for (int k = 0; k < MO; k++) begin
            #1;
            tests++; if (req_rdy !== 4'b0010) begin fails++; $display("FAIL full_grant[%0d] got %b want 0010", k, req_rdy); end
            cyc();
            tests++; if (mem_req_transid !== 6'(k)) begin fails++; $display("FAIL full_transid[%0d] got %0d want %0d", k, mem_req_transid, k); end
        end
        tests++; if (outst_cnt !== 5'd16) begin fails++; $display("FAIL full_cnt got %0d want 16", outst_cnt); end
        tests++; if (req_rdy !== 4'b0000) begin fails++; $display("FAIL full_blocked got %b want 0000", req_rdy); end
        cyc();
        tests++; if (mem_req_val !== 1'b0 || req_rdy !== 4'b0000) begin
            fails++; $display("FAIL full_hold got val=%b rdy=%b want val=0 rdy=0000", mem_req_val, req_rdy);
        end
        mem_resp_val = 1'b1;
        mem_resp_transid = 6'd7;
        mem_resp_data = 64'h7777;
        #1;
        tests++; if (req_rdy !== 4'b0000) begin fails++; $display("FAIL full_pre_edge got %b want 0000", req_rdy); end
        cyc();
        mem_resp_val = 1'b0;
        tests++; if (resp_val !== 4'b0010 || resp_tag !== 4'd5) begin
            fails++; $display("FAIL full_resp got val=%b tag=%0d want val=0010 tag=5", resp_val, resp_tag);
        end
        tests++; if (outst_cnt !== 5'd15) begin fails++; $display("FAIL full_cnt15 got %0d want 15", outst_cnt); end
        #1;
        tests++; if (req_rdy !== 4'b0010) begin fails++; $display("FAIL full_regrant got %b want 0010", req_rdy); end
        cyc();
        req_val = 4'b0000;
        tests++; if (mem_req_val !== 1'b1 || mem_req_transid !== 6'd7) begin
            fails++; $display("FAIL full_reuse got val=%b id=%0d want val=1 id=7", mem_req_val, mem_req_transid);
        end
        tests++; if (outst_cnt !== 5'd16) begin fails++; $display("FAIL full_cnt_again got %0d want 16", outst_cnt); end
        cyc();
    endtask

    task automatic test_drain_reset;
        do_reset();
        req_val = 4'b0100;
        req_addr[2*AW +: AW] = 40'h5000;
        mem_req_rdy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req_tag[2*GW +: GW] = 4'(k + 1);
            cyc();
        end
        drain = 1'b1;
        mem_req_rdy = 1'b0;
        cyc();
        tests++; if (mem_req_val !== 1'b1 || mem_req_transid !== 6'd2) begin
            fails++; $display("FAIL drain_pending got val=%b id=%0d want val=1 id=2", mem_req_val, mem_req_transid);
        end
        mem_req_rdy = 1'b1;
        #1;
        tests++; if (req_rdy !== 4'b0000) begin fails++; $display("FAIL drain_no_grant got %b want 0000", req_rdy); end
        cyc();
        tests++; if (mem_req_val !== 1'b0 || outst_cnt !== 5'd3 || idle !== 1'b0) begin
            fails++; $display("FAIL drain_issued got val=%b cnt=%0d idle=%b want val=0 cnt=3 idle=0", mem_req_val, outst_cnt, idle);
        end
        for (int j = 0; j < 3; j++) begin
            mem_resp_val = 1'b1;
            mem_resp_transid = 6'(j);
            mem_resp_data = 64'(j + 100);
            cyc();
            tests++; if (resp_val !== 4'b0100 || resp_tag !== 4'(j + 1)) begin
                fails++; $display("FAIL drain_resp[%0d] got val=%b tag=%0d want val=0100 tag=%0d", j, resp_val, resp_tag, j + 1);
            end
        end
        mem_resp_val = 1'b0;
        tests++; if (idle !== 1'b1 || outst_cnt !== 5'd0) begin
            fails++; $display("FAIL drain_idle got idle=%b cnt=%0d want idle=1 cnt=0", idle, outst_cnt);
        end
        tests++; if (req_rdy !== 4'b0000) begin fails++; $display("FAIL drain_still_blocked got %b want 0000", req_rdy); end
        drain = 1'b0;
        req_val = 4'b0001;
        mem_req_rdy = 1'b0;
        cyc();
        tests++; if (mem_req_val !== 1'b1 || outst_cnt !== 5'd1) begin
            fails++; $display("FAIL midflight_setup got val=%b cnt=%0d want val=1 cnt=1", mem_req_val, outst_cnt);
        end
        rst_n = 1'b0;
        #2;
        tests++; if (mem_req_val !== 1'b0 || outst_cnt !== 5'd0 || idle !== 1'b1) begin
            fails++; $display("FAIL midflight_reset got val=%b cnt=%0d idle=%b want val=0 cnt=0 idle=1", mem_req_val, outst_cnt, idle);
        end
        tests++; if (req_rdy !== 4'b0000 || resp_val !== 4'b0000) begin
            fails++; $display("FAIL midflight_outputs got rdy=%b resp=%b want 0000 0000", req_rdy, resp_val);
        end
        req_val = 4'b0000;
        cyc();
        rst_n = 1'b1;
        mem_resp_val = 1'b1;
        mem_resp_transid = 6'd0;
        cyc();
        mem_resp_val = 1'b0;
        tests++; if (resp_val !== 4'b0000 || err_stray !== 1'b1) begin
            fails++; $display("FAIL late_resp got resp=%b stray=%b want resp=0000 stray=1", resp_val, err_stray);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_out_of_order();
        test_backpressure();
        test_full();
        test_drain_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout after %0d tests", tests);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/spmv_mem_arb.md
Name: spmv_mem_arb

Overview:
Shares the single DCP NoC memory request/response port between the SpMV fetch engines: vec_file prefetch, row-pointer fetch, column-index fetch and value fetch.
- Arbitrates requests round-robin.
- Allocates a global transaction ID from an outstanding-request table.
- Routes each response to its owner along with that owner's local tag.
- Sits between the SpMV engines and the DCP NoC interface.

Parameters:
NUM_REQ, 4, number of requesters (index 0 = vec_file)
ADDR_W, 40, physical address width (DCP_PADDR_MASK)
DATA_W, 64, response data width (DCP_NOC_RES_DATA_SIZE)
TID_W, 6, NoC transid width
TAG_W, 4, requester-local tag width
MAX_OUTST, 16, outstanding table depth (power of 2, at most 2^TID_W)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
drain  in  1  block new grants (used around spmv_init)
req_val  in  NUM_REQ  per-requester request valid
req_addr  in  NUM_REQ x ADDR_W  per-requester address
req_tag  in  NUM_REQ x TAG_W  per-requester local tag
req_rdy  out  NUM_REQ  grant/accept, one-hot or zero
mem_req_val  out  1  NoC request valid
mem_req_rdy  in  1  NoC ready
mem_req_transid  out  TID_W  allocated table index, zero-extended
mem_req_addr  out  ADDR_W  request address
mem_resp_val  in  1  NoC response valid
mem_resp_transid  in  TID_W  response ID
mem_resp_data  in  DATA_W  response data
resp_val  out  NUM_REQ  one-hot response strobe to owner
resp_tag  out  TAG_W  local tag of returning request
resp_data  out  DATA_W  returned data, shared bus
outst_cnt  out  $clog2(MAX_OUTST)+1  valid table entries
idle  out  1  outst_cnt==0 and output register empty
err_stray  out  1  sticky: response to an invalid entry

Behaviour:
- Reset: every output 0, except idle=1 and req_rdy=0. Table cleared. RR pointer = 0. err_stray cleared (reset is its only clear).
- Output register: {mem_req_val, transid, addr} stays stable while mem_req_val=1 and mem_req_rdy=0. It frees on mem_req_val and mem_req_rdy.
- Grant condition, evaluated combinationally in a cycle:
  - some req_val is high, and
  - drain=0, and
  - the free bitmap has at least one bit set (registered state), and
  - the output register is empty or being accepted this cycle.
- Grant mechanics:
  - Winner = first requester with req_val at or after the RR pointer, wrapping.
  - req_rdy[winner]=1 in the same cycle.
  - req_val must not depend on req_rdy.
- Grant side effects at the next edge:
  - Output register loads {1, lowest free index, req_addr[winner]}.
  - Entry marked valid with {owner=winner, tag=req_tag[winner]}.
  - RR pointer = winner+1 mod NUM_REQ.
- Request latency: grant cycle, then mem_req_val high the following cycle. Back-to-back grants are sustained at 1 per cycle while mem_req_rdy=1.
- Response handling, when mem_resp_val is high and entry[transid] is valid:
  - One cycle later: resp_val[owner]=1, resp_tag=entry tag, resp_data registered.
  - The entry is freed at the same edge the response is registered.
- Invalid response: transid >= MAX_OUTST or entry invalid. The response is dropped, resp_val stays 0 and err_stray is set.
- Simultaneous free and allocate in one cycle: allocation uses the pre-edge bitmap, so a freed index is reusable from the next cycle. outst_cnt nets +1-1=0.
- Full: all MAX_OUTST entries valid means req_rdy=0 for all requesters. Responses keep flowing.
- drain=1:
  - No new grants.
  - A pending output request still issues.
  - Outstanding responses still route.
  - idle rises once fully drained.
- Async reset mid-transaction discards all state. Late NoC responses arriving after reset hit invalid entries and set err_stray.

Decomposition:
- Package spmv_mem_pkg:
  - typedef mem_entry_t {valid, owner[$clog2(NUM_REQ)], tag[TAG_W]}.
  - Requester index constants: REQ_VEC=0, REQ_ROWPTR=1, REQ_COLIDX=2, REQ_VAL=3.
  - Default widths.
- Sub-module rr_arbiter: NUM_REQ-wide, request vector plus pointer in, one-hot grant out, combinational. Instantiated once.
- Free-index priority encoder stays inline.

Test Plan:
- Single request: after reset, req_val[0]=1, addr=0x1000, tag=3, mem_req_rdy=1 -> req_rdy[0] same cycle; next cycle mem_req_val=1, transid=0, addr=0x1000. Response transid=0, data=0xA5A5A5A5A5A5A5A5 -> next cycle resp_val=4'b0001, tag=3, outst_cnt back to 0, idle=1.
- Round-robin: all four req_val held high -> grant order 0,1,2,3,0, with transids 0,1,2,3,4 on consecutive cycles.
- Backpressure: mem_req_rdy=0 for 5 cycles with a request pending -> mem_req_transid/addr stable, no further req_rdy; on release, the next grant proceeds at 1 per cycle.
- Full table: 16 grants with no responses -> outst_cnt=16, req_rdy=0. Respond transid=7 -> next grant reuses transid 7 one cycle after the free.
- Out-of-order and stray responses: responses 2,0,1 -> owners/tags routed correctly. Response transid=9 with entry 9 invalid -> dropped, err_stray=1 sticky.
- Drain and reset: drain=1 with 3 outstanding -> no grants; idle=1 after the 3rd response. rst_n pulsed mid-flight -> all outputs reset, idle=1.
